uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single on-chip UART transmitter (8-bit ready/valid `data_in` port) among several byte-stream requesters, for example the CPU memory-mapped store path at 0x80000008 and a hardware debug or status streamer. It grants whole packets, delimited by a per-requester `last` flag. A burst-length limit prevents any one requester from starving the others. The block sits between the requesters and the `uart` instance inside `ml505top`.

---
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART transmitter among byte-stream requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 grant_valid,
    output logic [1:0]           grant_id
);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     data_ext;
    logic [3:0]      valid_ext;
    logic [3:0]      last_ext;
    logic [1:0]      winner;
    logic [1:0]      idx;
    logic            found;
    logic            hs;

    // Requester buses widened to the 4-requester maximum so a 2-bit owner indexes them directly.
    assign data_ext  = 32'(req_data);
    assign valid_ext = 4'(req_valid);
    assign last_ext  = 4'(req_last);

    assign grant_valid = (state_q == LOCKED);
    assign grant_id    = owner_q;
    assign tx_data     = data_ext[{owner_q, 3'b000} +: 8];
    assign tx_valid    = (state_q == LOCKED) && valid_ext[owner_q];
    assign hs          = tx_valid && tx_ready;

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = (state_q == LOCKED) && (owner_q == 2'(g)) && tx_ready;
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = 2'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && valid_ext[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Grant FSM: lock onto a winner, release on packet end or burst limit.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        count_d  = count_q;
        if (state_q == IDLE) begin
            if (found) begin
                state_d = LOCKED;
                owner_d = winner;
                count_d = '0;
            end
        end else if (hs) begin
            count_d = count_q + 1'b1;
            if (last_ext[owner_q] || (int'(count_q) + 1 == MAX_BURST)) begin
                state_d  = IDLE;
                rr_ptr_d = 2'((int'(owner_q) + 1) % NUM_REQ);
            end
        end
    end

    // State registers with synchronous reset; an in-flight packet is abandoned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter (NUM_REQ=2, MAX_BURST=4)
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  d0 = '0, d1 = '0;
    logic        v0 = 1'b0, v1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        grant_valid;
    logic [1:0]  grant_id;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  log_d[$];
    logic        log_id[$];
    int          log_cyc[$];
    int          start;

    uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(4)) dut (
        .clk(clk),
        .reset(reset),
        .req_data({d1, d0}),
        .req_valid({v1, v0}),
        .req_last({l1, l0}),
        .req_ready(req_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .grant_valid(grant_valid),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Record every byte handed to the UART with its owner and cycle number.
    always @(posedge clk) begin
        cyc++;
        if (tx_valid && tx_ready) begin
            log_d.push_back(tx_data);
            log_id.push_back(grant_id[0]);
            log_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic log_clear();
        log_d.delete();
        log_id.delete();
        log_cyc.delete();
    endtask

    task automatic check_log(input int i, input bit id, input logic [7:0] d);
        check("log_id", (i < log_id.size()) ? 32'(log_id[i]) : 32'hdead, 32'(id));
        check("log_data", (i < log_d.size()) ? 32'(log_d[i]) : 32'hdead, 32'(d));
    endtask

    task automatic wait_log(input int n);
        for (int i = 0; i < 200 && log_d.size() < n; i++) tick();
        if (log_d.size() < n) check("wait_log_timeout", 0, 1);
    endtask

    // Present one byte on requester r and hold it until accepted.
    task automatic put(input bit r, input logic [7:0] d, input bit l);
        bit done = 1'b0;
        if (r) begin v1 = 1'b1; d1 = d; l1 = l; end
        else begin v0 = 1'b1; d0 = d; l0 = l; end
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            if (req_ready[r] && tx_valid) begin
                check("put_grant_id", 32'(grant_id), 32'(r));
                check("put_tx_data", 32'(tx_data), 32'(d));
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("put_timeout", 0, 1);
        if (r) begin v1 = 1'b0; l1 = 1'b0; end
        else begin v0 = 1'b0; l0 = 1'b0; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        #1;
        check("rst_tx_valid", 32'(tx_valid), 0);
        check("rst_grant_valid", 32'(grant_valid), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        tick();

        // Single packet from requester 0.
        log_clear();
        v0 = 1'b1; d0 = 8'h7A;
        #1;
        check("idle_tx_valid", 32'(tx_valid), 0);
        check("idle_req_ready", 32'(req_ready), 0);
        put(0, 8'h7A, 0);
        put(0, 8'h41, 0);
        put(0, 8'h0A, 1);
        check("sp_grant_valid_low", 32'(grant_valid), 0);
        check("sp_grant_id_held", 32'(grant_id), 0);
        check("sp_rr_ptr", 32'(dut.rr_ptr_q), 1);
        check("sp_log_size", log_d.size(), 3);
        check_log(0, 0, 8'h7A);
        check_log(1, 0, 8'h41);
        check_log(2, 0, 8'h0A);
        check("sp_back_to_back", log_cyc[2] - log_cyc[0], 2);

        // Round-robin: simultaneous requests right after reset.
        do_reset();
        log_clear();
        fork
            begin put(0, 8'hA0, 0); put(0, 8'hA1, 1); end
            put(1, 8'h55, 1);
        join
        check("rr_log_size", log_d.size(), 3);
        check_log(0, 0, 8'hA0);
        check_log(1, 0, 8'hA1);
        check_log(2, 1, 8'h55);
        check("rr_gap", log_cyc[2] - log_cyc[1], 2);
        fork
            put(0, 8'h11, 1);
            put(1, 8'h22, 1);
        join
        check_log(3, 0, 8'h11);
        check_log(4, 1, 8'h22);

        // Burst limit: forced release after 4 bytes, requester 1 goes next.
        do_reset();
        log_clear();
        fork
            begin
                put(0, 8'hB1, 0); put(0, 8'hB2, 0); put(0, 8'hB3, 0);
                put(0, 8'hB4, 0); put(0, 8'hB5, 0); put(0, 8'hB6, 1);
            end
            begin tick(); put(1, 8'h99, 1); end
        join
        check("bl_log_size", log_d.size(), 7);
        check_log(3, 0, 8'hB4);
        check_log(4, 1, 8'h99);
        check_log(5, 0, 8'hB5);
        check_log(6, 0, 8'hB6);
        check("bl_release_gap", log_cyc[4] - log_cyc[3], 2);

        // Back-pressure mid-packet for 20 cycles.
        log_clear();
        fork
            begin put(0, 8'hC1, 0); put(0, 8'hC2, 0); put(0, 8'hC3, 1); end
            begin
                wait_log(1);
                tx_ready = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    #2;
                    check("bp_req_ready", 32'(req_ready), 0);
                    check("bp_tx_data", 32'(tx_data), 32'h C2);
                    check("bp_count", 32'(dut.count_q), 1);
                    tick();
                end
                tx_ready = 1'b1;
            end
        join
        check("bp_log_size", log_d.size(), 3);
        check_log(1, 0, 8'hC2);
        check_log(2, 0, 8'hC3);

        // Reset after byte 2 of a 5-byte packet from requester 1.
        log_clear();
        put(1, 8'hD1, 0);
        put(1, 8'hD2, 0);
        check("mr_grant_id_before", 32'(grant_id), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_tx_valid", 32'(tx_valid), 0);
        check("mr_grant_valid", 32'(grant_valid), 0);
        check("mr_grant_id", 32'(grant_id), 0);
        check("mr_rr_ptr", 32'(dut.rr_ptr_q), 0);
        start = cyc;
        put(0, 8'h5A, 1);
        check("mr_log_size", log_d.size(), 3);
        check_log(2, 0, 8'h5A);
        check("mr_regrant_latency", log_cyc[2] - start, 2);

        // Owner stall: requester 0 drops valid for 8 cycles while requester 1 waits.
        tick();
        log_clear();
        put(0, 8'hE1, 0);
        v1 = 1'b1; d1 = 8'h33; l1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("os_grant_id", 32'(grant_id), 0);
            check("os_grant_valid", 32'(grant_valid), 1);
            check("os_req_ready1", 32'(req_ready[1]), 0);
            check("os_tx_valid", 32'(tx_valid), 0);
            tick();
        end
        put(0, 8'hE2, 0);
        put(0, 8'hE3, 1);
        put(1, 8'h33, 1);
        check("os_log_size", log_d.size(), 4);
        check_log(0, 0, 8'hE1);
        check_log(1, 0, 8'hE2);
        check_log(2, 0, 8'hE3);
        check_log(3, 1, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
